nbdcache_array_arbiter: RTL and testbench

// - N-port arbiter, tag comparator and set-array sequencer for the non-blocking L1 dcache; generalises the fixed 4-port tag compare path.
// - Sits between the miss handler/cache controllers and the per-way data/tag/valid-dirty SRAMs.
// - Adds a parametrised port count, fair round-robin among controller ports and a hardware invalidation sweep on reset/init.

---
 rtl/nbdcache_array_arbiter_if.sv | 47 ++++
 rtl/nbdcache_array_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_nbdcache_array_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nbdcache_array_arbiter_if.sv
// nbdcache_array_arbiter_if
//   Requester-side bus of the dcache array arbiter. Each field is a flat
//   vector of per-port (or per-way) slices, port p occupying slice p.
//   Fields:
//     req     NR_PORTS*NR_WAYS          per-port way-select request
//     idx     NR_PORTS*IDX_W            per-port set index
//     tag     NR_PORTS*TAG_W            per-port compare tag
//     we      NR_PORTS                  per-port write enable
//     wdata   NR_PORTS*DW               {valid,dirty,tag,data}
//     be      NR_PORTS*BEW              {vldrty,tag bytes,data bytes}
//     gnt     NR_PORTS                  one-hot grant (combinational)
//     rvalid  NR_PORTS                  one-hot read-return strobe
//     rdata   NR_WAYS*DW                all-way read data
//     hit_way NR_WAYS                   valid && tag match per way
//   Modports: master = requesters, slave = arbiter.
interface nbdcache_array_arbiter_if #(
  parameter int NR_PORTS = 4,
  parameter int NR_WAYS  = 8,
  parameter int NUM_SETS = 256,
  parameter int TAG_W    = 44,
  parameter int LINE_W   = 128
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int DW    = LINE_W + TAG_W + 2;
  localparam int BEW   = LINE_W / 8 + TAG_W / 8 + 1;

  logic [NR_PORTS*NR_WAYS-1:0] req;
  logic [NR_PORTS*IDX_W-1:0]   idx;
  logic [NR_PORTS*TAG_W-1:0]   tag;
  logic [NR_PORTS-1:0]         we;
  logic [NR_PORTS*DW-1:0]      wdata;
  logic [NR_PORTS*BEW-1:0]     be;
  logic [NR_PORTS-1:0]         gnt;
  logic [NR_PORTS-1:0]         rvalid;
  logic [NR_WAYS*DW-1:0]       rdata;
  logic [NR_WAYS-1:0]          hit_way;

  modport master (
    output req, idx, tag, we, wdata, be,
    input  gnt, rvalid, rdata, hit_way
  );

  modport slave (
    input  req, idx, tag, we, wdata, be,
    output gnt, rvalid, rdata, hit_way
  );
endinterface

// File: rtl/nbdcache_array_arbiter.sv
// nbdcache_array_arbiter
//   N-port arbiter, tag comparator and set-array sequencer for the
//   non-blocking L1 dcache. After reset (or an init_i pulse) it sweeps every
//   set, clearing valid/dirty in all ways, then arbitrates requester access
//   to the single-ported per-way SRAM bundle.
//   Ports:
//     clk_i, rst_ni       clock, synchronous active-low reset
//     init_i              pulse: restart the invalidation sweep
//     init_done_o         sweep finished, requests accepted
//     bus_if (slave)      requester bus (req/idx/tag/we/wdata/be, gnt/rvalid/rdata/hit_way)
//     ram_req_o..ram_be_o SRAM request bundle (way select, we, index, data, byte enables)
//     ram_rdata_i         SRAM read data, one cycle after the request
//     conflict_cnt_o      only with NBDCACHE_ARB_CONFLICT_CNT_EN: saturating
//                         count of RUN cycles with a requester left waiting
//     dbg_state_o         current FSM state (0 = INIT, 1 = RUN)
//   Optional feature macro: NBDCACHE_ARB_CONFLICT_CNT_EN.
//
//   Handshake: a port requests by holding any bit of its req slice high with
//   idx/tag/we/wdata/be stable; the transfer happens in the cycle gnt[p] is
//   high. An ungranted port must keep its request asserted; nothing is queued
//   internally. Reads return rvalid[p] exactly one cycle after the grant.
module nbdcache_array_arbiter #(
  parameter int NR_PORTS = 4,
  parameter int NR_WAYS  = 8,
  parameter int NUM_SETS = 256,
  parameter int TAG_W    = 44,
  parameter int LINE_W   = 128,
  parameter int IDX_W    = $clog2(NUM_SETS),
  localparam int DW      = LINE_W + TAG_W + 2,
  localparam int BEW     = LINE_W / 8 + TAG_W / 8 + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    init_i,
  output logic                    init_done_o,
  nbdcache_array_arbiter_if.slave bus_if,
  output logic [NR_WAYS-1:0]      ram_req_o,
  output logic                    ram_we_o,
  output logic [IDX_W-1:0]        ram_idx_o,
  output logic [DW-1:0]           ram_wdata_o,
  output logic [BEW-1:0]          ram_be_o,
  input  logic [NR_WAYS*DW-1:0]   ram_rdata_i,
`ifdef NBDCACHE_ARB_CONFLICT_CNT_EN
  output logic [31:0]             conflict_cnt_o,
`endif
  output logic                    dbg_state_o
);

  localparam int PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  // Sweep writes touch only the valid/dirty field.
  localparam logic [BEW-1:0] VLDRTY_BE = {1'b1, {(BEW-1){1'b0}}};

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [NR_PORTS-1:0] rvalid_q, rvalid_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [NR_PORTS-1:0] port_req;
  logic [NR_PORTS-1:0] gnt;
  logic                gnt_en;
  logic                arb_any;
  logic [PW-1:0]       arb_idx;
  logic [NR_WAYS-1:0]  hit;

  always_comb begin
    port_req = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      port_req[p] = |bus_if.req[p*NR_WAYS +: NR_WAYS];
    end
  end

  // Winner selection: port 0 always first; otherwise the lowest requesting
  // port at or after rr_q, falling back to the lowest one below rr_q.
  if (NR_PORTS == 1) begin : g_single
    assign arb_any = port_req[0];
    assign arb_idx = '0;
  end else begin : g_rr
    logic [PW-1:0] rr_q, rr_d;
    logic          found_hi, found_lo;
    logic [PW-1:0] idx_hi, idx_lo;

    always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      // Descending scan so the last hit kept is the lowest index.
      for (int p = NR_PORTS - 1; p >= 1; p--) begin
        if (port_req[p]) begin
          if (p >= int'(rr_q)) begin
            found_hi = 1'b1;
            idx_hi   = PW'(p);
          end else begin
            found_lo = 1'b1;
            idx_lo   = PW'(p);
          end
        end
      end
      arb_any = 1'b0;
      arb_idx = '0;
      if (port_req[0]) begin
        arb_any = 1'b1;
      end else if (found_hi) begin
        arb_any = 1'b1;
        arb_idx = idx_hi;
      end else if (found_lo) begin
        arb_any = 1'b1;
        arb_idx = idx_lo;
      end
    end

    // Pointer only advances past a round-robin winner; port 0 leaves it alone.
    always_comb begin
      rr_d = rr_q;
      if (gnt_en && (arb_idx != '0)) begin
        rr_d = (arb_idx == PW'(NR_PORTS - 1)) ? PW'(1) : arb_idx + PW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rr_q <= PW'(1);
      end else begin
        rr_q <= rr_d;
      end
    end
  end

  assign gnt_en = (state_q == ST_RUN) && arb_any;

  always_comb begin
    gnt = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      gnt[p] = gnt_en && (arb_idx == PW'(p));
    end
  end

  // FSM next state plus SRAM bundle mux.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rvalid_d    = '0;
    tag_d       = tag_q;
    ram_req_o   = '0;
    ram_we_o    = 1'b0;
    ram_idx_o   = '0;
    ram_wdata_o = '0;
    ram_be_o    = '0;
    unique case (state_q)
      ST_INIT: begin
        // Gated by rst_ni so the bundle stays quiet while reset is held.
        if (rst_ni) begin
          ram_req_o = '1;
          ram_we_o  = 1'b1;
          ram_idx_o = cnt_q;
          ram_be_o  = VLDRTY_BE;
        end
        if (init_i) begin
          cnt_d = '0;
        end else if (cnt_q == IDX_W'(NUM_SETS - 1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        for (int p = 0; p < NR_PORTS; p++) begin
          if (gnt[p]) begin
            ram_req_o   = bus_if.req[p*NR_WAYS +: NR_WAYS];
            ram_we_o    = bus_if.we[p];
            ram_idx_o   = bus_if.idx[p*IDX_W +: IDX_W];
            ram_wdata_o = bus_if.wdata[p*DW +: DW];
            ram_be_o    = bus_if.be[p*BEW +: BEW];
            rvalid_d[p] = ~bus_if.we[p];
            tag_d       = bus_if.tag[p*TAG_W +: TAG_W];
          end
        end
        if (init_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // rvalid_q is not touched by init_i, so a read granted just before a
  // restart still completes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      rvalid_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      tag_q    <= tag_d;
    end
  end

  // Hit compare against the tag captured at grant; forced low when no read returns.
  always_comb begin
    hit = '0;
    for (int w = 0; w < NR_WAYS; w++) begin
      hit[w] = (|rvalid_q) && ram_rdata_i[w*DW + DW - 1] &&
               (ram_rdata_i[w*DW + LINE_W +: TAG_W] == tag_q);
    end
  end

  assign bus_if.gnt     = gnt;
  assign bus_if.rvalid  = rvalid_q;
  assign bus_if.rdata   = ram_rdata_i;
  assign bus_if.hit_way = hit;
  assign init_done_o    = (state_q == ST_RUN);
  assign dbg_state_o    = state_q;

`ifdef NBDCACHE_ARB_CONFLICT_CNT_EN
  logic [31:0] conf_q, conf_d;

  always_comb begin
    conf_d = conf_q;
    if (init_i) begin
      conf_d = '0;
    end else if ((state_q == ST_RUN) && (|(port_req & ~gnt)) && (conf_q != 32'hFFFF_FFFF)) begin
      conf_d = conf_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conf_q <= '0;
    end else begin
      conf_q <= conf_d;
    end
  end

  assign conflict_cnt_o = conf_q;
`endif

endmodule

// File: tb/tb_nbdcache_array_arbiter.sv
`timescale 1ns/1ps
module tb_nbdcache_array_arbiter;
  localparam int P   = 4;
  localparam int W   = 8;
  localparam int S   = 8;
  localparam int TW  = 44;
  localparam int LW  = 128;
  localparam int IW  = 3;
  localparam int DW  = LW + TW + 2;
  localparam int BEW = LW / 8 + TW / 8 + 1;
  localparam logic [BEW-1:0] VLDRTY_BE = {1'b1, {(BEW-1){1'b0}}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic init_i = 1'b0;
  always #5 clk = ~clk;

  logic              init_done;
  logic [W-1:0]      ram_req;
  logic              ram_we;
  logic [IW-1:0]     ram_idx;
  logic [DW-1:0]     ram_wdata;
  logic [BEW-1:0]    ram_be;
  logic [W*DW-1:0]   ram_rdata = '0;
  logic              dbg_state;
`ifdef NBDCACHE_ARB_CONFLICT_CNT_EN
  logic [31:0]       conflict_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  nbdcache_array_arbiter_if #(.NR_PORTS(P), .NR_WAYS(W), .NUM_SETS(S), .TAG_W(TW), .LINE_W(LW)) bus_if ();

  nbdcache_array_arbiter #(.NR_PORTS(P), .NR_WAYS(W), .NUM_SETS(S), .TAG_W(TW), .LINE_W(LW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .init_i      (init_i),
    .init_done_o (init_done),
    .bus_if      (bus_if),
    .ram_req_o   (ram_req),
    .ram_we_o    (ram_we),
    .ram_idx_o   (ram_idx),
    .ram_wdata_o (ram_wdata),
    .ram_be_o    (ram_be),
    .ram_rdata_i (ram_rdata),
`ifdef NBDCACHE_ARB_CONFLICT_CNT_EN
    .conflict_cnt_o (conflict_cnt),
`endif
    .dbg_state_o (dbg_state)
  );

  // ---------------- SRAM model (1-cycle read latency) ----------------
  logic [DW-1:0] mem [W][S];

  initial begin
    for (int w = 0; w < W; w++)
      for (int s = 0; s < S; s++)
        mem[w][s] = DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  end

  always @(posedge clk) begin
    if (|ram_req) begin
      if (ram_we) begin
        for (int w = 0; w < W; w++) begin
          if (ram_req[w]) begin
            for (int b = 0; b < LW / 8; b++)
              if (ram_be[b]) mem[w][ram_idx][b*8 +: 8] = ram_wdata[b*8 +: 8];
            if (|ram_be[BEW-2:LW/8]) mem[w][ram_idx][LW +: TW] = ram_wdata[LW +: TW];
            if (ram_be[BEW-1]) mem[w][ram_idx][DW-1 -: 2] = ram_wdata[DW-1 -: 2];
          end
        end
      end else begin
        for (int w = 0; w < W; w++) ram_rdata[w*DW +: DW] <= mem[w][ram_idx];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic [W-1:0] ways, input logic [IW-1:0] idx,
                          input logic [TW-1:0] tag, input logic we, input logic [DW-1:0] wd,
                          input logic [BEW-1:0] be);
    bus_if.req[p*W +: W]       = ways;
    bus_if.idx[p*IW +: IW]     = idx;
    bus_if.tag[p*TW +: TW]     = tag;
    bus_if.we[p]               = we;
    bus_if.wdata[p*DW +: DW]   = wd;
    bus_if.be[p*BEW +: BEW]    = be;
  endtask

  task automatic clr_all();
    bus_if.req   = '0;
    bus_if.idx   = '0;
    bus_if.tag   = '0;
    bus_if.we    = '0;
    bus_if.wdata = '0;
    bus_if.be    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    init_i = 1'b0;
    clr_all();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (S) @(negedge clk);
  endtask

  // Reference arbitration: port 0 first, then first pending at/after rr, wrapping over 1..P-1.
  function automatic int model_grant(input logic [P-1:0] pend, input int rr);
    if (pend[0]) return 0;
    for (int k = 0; k < P - 1; k++) begin
      int q;
      q = 1 + ((rr - 1 + k) % (P - 1));
      if (pend[q]) return q;
    end
    return -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W+1+IW+DW+BEW-1:0] exp_bundle;
    @(negedge clk);
    rst_ni = 1'b0;
    clr_all();
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if ({bus_if.gnt, bus_if.rvalid, bus_if.hit_way, init_done} !== '0) $display("FAIL reset_outs gnt=%h rvalid=%h hit=%h done=%b expected all 0", bus_if.gnt, bus_if.rvalid, bus_if.hit_way, init_done);
    else n_pass++;
    n_total++;
    if ({ram_req, ram_we, ram_idx, ram_wdata, ram_be} !== '0) $display("FAIL reset_ram req=%h we=%b idx=%h be=%h expected 0", ram_req, ram_we, ram_idx, ram_be);
    else n_pass++;
    for (int p = 0; p < P; p++) set_port(p, 8'hFF, '0, '0, 1'b0, '0, '0);
    rst_ni = 1'b1;
    for (int c = 0; c < S; c++) begin
      #1;
      exp_bundle = {8'hFF, 1'b1, IW'(c), DW'(0), VLDRTY_BE};
      n_total++;
      if ({ram_req, ram_we, ram_idx, ram_wdata, ram_be} !== exp_bundle) $display("FAIL sweep_write c=%0d req=%h we=%b idx=%0d be=%h expected idx=%0d", c, ram_req, ram_we, ram_idx, ram_be, c);
      else n_pass++;
      n_total++;
      if ({bus_if.gnt, init_done} !== '0) $display("FAIL sweep_no_gnt c=%0d gnt=%b done=%b expected 0", c, bus_if.gnt, init_done);
      else n_pass++;
      @(negedge clk);
    end
    clr_all();
    #1;
    n_total++;
    if (init_done !== 1'b1) $display("FAIL init_done got %b expected 1", init_done);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [P-1:0] exp_q[$];
    logic [P-1:0] exp;
    @(negedge clk);
    exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
    for (int p = 1; p < P; p++) set_port(p, 8'hFF, IW'(p), '0, 1'b0, '0, '0);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      #1;
      n_total++;
      if (bus_if.gnt !== exp) $display("FAIL rr_gnt got %b expected %b", bus_if.gnt, exp);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (bus_if.rvalid !== exp) $display("FAIL rr_rvalid got %b expected %b", bus_if.rvalid, exp);
      else n_pass++;
    end
    clr_all();
  endtask

  task automatic test_priority();
    @(negedge clk);
    set_port(0, 8'hFF, 3'd1, '0, 1'b0, '0, '0);
    set_port(2, 8'hFF, 3'd2, '0, 1'b0, '0, '0);
    #1;
    n_total++;
    if (bus_if.gnt !== 4'b0001) $display("FAIL prio_gnt0 got %b expected 0001", bus_if.gnt);
    else n_pass++;
    @(negedge clk);
    set_port(0, '0, '0, '0, 1'b0, '0, '0);
    #1;
    n_total++;
    if ({bus_if.gnt, bus_if.rvalid} !== {4'b0100, 4'b0001}) $display("FAIL prio_held gnt=%b rvalid=%b expected 0100/0001", bus_if.gnt, bus_if.rvalid);
    else n_pass++;
    @(negedge clk);
    clr_all();
    #1;
    n_total++;
    if ({bus_if.gnt, bus_if.rvalid} !== {4'b0000, 4'b0100}) $display("FAIL prio_ret gnt=%b rvalid=%b expected 0000/0100", bus_if.gnt, bus_if.rvalid);
    else n_pass++;
  endtask

  task automatic test_hit();
    logic [DW-1:0] wd;
    logic [TW-1:0] tags [3];
    logic [W-1:0]  hits [3];
    wd = {1'b1, 1'b0, 44'hABC, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677};
    tags = '{44'hABC, 44'hABD, 44'hABC};
    hits = '{8'b0000_1000, 8'h00, 8'h00};
    @(negedge clk);
    set_port(3, 8'b0000_1000, 3'd5, '0, 1'b1, wd, '1);
    #1;
    n_total++;
    if ({bus_if.gnt, ram_req, ram_we, ram_idx, ram_wdata} !== {4'b1000, 8'b0000_1000, 1'b1, 3'd5, wd}) $display("FAIL hit_write gnt=%b req=%h we=%b idx=%0d", bus_if.gnt, ram_req, ram_we, ram_idx);
    else n_pass++;
    @(negedge clk);
    clr_all();
    #1;
    n_total++;
    if ({bus_if.rvalid, bus_if.hit_way} !== '0) $display("FAIL write_no_rvalid rvalid=%b hit=%b expected 0", bus_if.rvalid, bus_if.hit_way);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        // Clear only the valid/dirty field of way 3.
        @(negedge clk);
        set_port(3, 8'b0000_1000, 3'd5, '0, 1'b1, '0, VLDRTY_BE);
        @(negedge clk);
        clr_all();
      end
      @(negedge clk);
      set_port(3, 8'hFF, 3'd5, tags[i], 1'b0, '0, '0);
      @(negedge clk);
      clr_all();
      #1;
      n_total++;
      if ({bus_if.rvalid, bus_if.hit_way} !== {4'b1000, hits[i]}) $display("FAIL hit_read%0d rvalid=%b hit=%b expected 1000/%b", i, bus_if.rvalid, bus_if.hit_way, hits[i]);
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if (bus_if.rdata[3*DW +: DW] !== wd) $display("FAIL hit_rdata got %h expected %h", bus_if.rdata[3*DW +: DW], wd);
        else n_pass++;
      end
    end
  endtask

  task automatic test_init_in_run();
    @(negedge clk);
    set_port(1, 8'hFF, 3'd0, '0, 1'b0, '0, '0);
    #1;
    n_total++;
    if (bus_if.gnt !== 4'b0010) $display("FAIL iir_gnt got %b expected 0010", bus_if.gnt);
    else n_pass++;
    @(negedge clk);
    clr_all();
    init_i = 1'b1;
    #1;
    n_total++;
    if ({init_done, bus_if.rvalid} !== {1'b1, 4'b0010}) $display("FAIL iir_rvalid done=%b rvalid=%b expected 1/0010", init_done, bus_if.rvalid);
    else n_pass++;
    @(negedge clk);
    init_i = 1'b0;
    set_port(1, 8'hFF, 3'd0, '0, 1'b0, '0, '0);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_total++;
      if ({init_done, bus_if.gnt, ram_req, ram_we, ram_idx} !== {1'b0, 4'b0000, 8'hFF, 1'b1, IW'(c)}) $display("FAIL iir_sweep c=%0d done=%b gnt=%b idx=%0d expected idx %0d", c, init_done, bus_if.gnt, ram_idx, c);
      else n_pass++;
      if (c == 3) init_i = 1'b1;
      @(negedge clk);
    end
    init_i = 1'b0;
    #1;
    n_total++;
    if ({init_done, ram_idx} !== {1'b0, IW'(0)}) $display("FAIL iir_restart done=%b idx=%0d expected 0/0", init_done, ram_idx);
    else n_pass++;
    clr_all();
    repeat (S) @(negedge clk);
    #1;
    n_total++;
    if (init_done !== 1'b1) $display("FAIL iir_done got %b expected 1", init_done);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [P-1:0]   pend;
    logic [W-1:0]   pw [P];
    logic [IW-1:0]  pi [P];
    logic [TW-1:0]  pt [P];
    logic           pwe [P];
    logic [DW-1:0]  pd [P];
    logic [BEW-1:0] pb [P];
    logic [P-1:0]   exp_rv, exp_gnt;
    logic [W-1:0]   exp_hit;
    logic [W*DW-1:0] exp_rd;
    int rr, g, prev_g;
    do_reset();
    pend = '0;
    rr = 1;
    exp_rv = '0;
    exp_hit = '0;
    exp_rd = '0;
    prev_g = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (prev_g >= 0) set_port(prev_g, '0, '0, '0, 1'b0, '0, '0);
      n_total++;
      if ({bus_if.rvalid, bus_if.hit_way} !== {exp_rv, exp_hit}) $display("FAIL rnd_ret cyc=%0d rvalid=%b hit=%b expected %b/%b", cyc, bus_if.rvalid, bus_if.hit_way, exp_rv, exp_hit);
      else n_pass++;
      if (exp_rv != '0) begin
        n_total++;
        if (bus_if.rdata !== exp_rd) $display("FAIL rnd_rdata cyc=%0d", cyc);
        else n_pass++;
      end
      for (int p = 0; p < P; p++) begin
        if (!pend[p] && ((p == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0))) begin
          pend[p] = 1'b1;
          pw[p]  = W'($urandom_range(1, 255));
          pi[p]  = IW'($urandom_range(0, S - 1));
          pt[p]  = ($urandom_range(0, 1) == 0) ? 44'hABC : 44'h123;
          pwe[p] = ($urandom_range(0, 2) == 0);
          pd[p]  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    (($urandom_range(0, 1) == 0) ? 44'hABC : 44'h123),
                    {$urandom, $urandom, $urandom, $urandom}};
          pb[p]  = BEW'({$urandom, $urandom});
          set_port(p, pw[p], pi[p], pt[p], pwe[p], pd[p], pb[p]);
        end
      end
      #1;
      g = model_grant(pend, rr);
      exp_gnt = (g < 0) ? '0 : P'(1) << g;
      n_total++;
      if (bus_if.gnt !== exp_gnt) $display("FAIL rnd_gnt cyc=%0d got %b expected %b", cyc, bus_if.gnt, exp_gnt);
      else n_pass++;
      exp_rv = '0;
      exp_hit = '0;
      if (g >= 0) begin
        n_total++;
        if ({ram_req, ram_we, ram_idx} !== {pw[g], pwe[g], pi[g]}) $display("FAIL rnd_ram cyc=%0d req=%h we=%b idx=%0d expected %h/%b/%0d", cyc, ram_req, ram_we, ram_idx, pw[g], pwe[g], pi[g]);
        else n_pass++;
        if (pwe[g]) begin
          n_total++;
          if ({ram_wdata, ram_be} !== {pd[g], pb[g]}) $display("FAIL rnd_wdata cyc=%0d be=%h expected %h", cyc, ram_be, pb[g]);
          else n_pass++;
        end else begin
          exp_rv = P'(1) << g;
          for (int w = 0; w < W; w++) begin
            exp_hit[w] = mem[w][pi[g]][DW-1] && (mem[w][pi[g]][LW +: TW] == pt[g]);
            exp_rd[w*DW +: DW] = mem[w][pi[g]];
          end
        end
        if (g > 0) rr = (g == P - 1) ? 1 : g + 1;
        pend[g] = 1'b0;
      end
      prev_g = g;
      @(negedge clk);
    end
    clr_all();
  endtask

`ifdef NBDCACHE_ARB_CONFLICT_CNT_EN
  task automatic test_conflict_cnt();
    do_reset();
    #1;
    n_total++;
    if (conflict_cnt !== 32'd0) $display("FAIL conf_reset got %0d expected 0", conflict_cnt);
    else n_pass++;
    for (int p = 1; p < P; p++) set_port(p, 8'hFF, IW'(p), '0, 1'b0, '0, '0);
    repeat (10) @(negedge clk);
    clr_all();
    #1;
    n_total++;
    if (conflict_cnt !== 32'd10) $display("FAIL conf_10 got %0d expected 10", conflict_cnt);
    else n_pass++;
    @(negedge clk);
    init_i = 1'b1;
    #1;
    n_total++;
    if (conflict_cnt !== 32'd10) $display("FAIL conf_hold got %0d expected 10", conflict_cnt);
    else n_pass++;
    @(negedge clk);
    init_i = 1'b0;
    #1;
    n_total++;
    if (conflict_cnt !== 32'd0) $display("FAIL conf_init got %0d expected 0", conflict_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clr_all();
    test_reset();
    test_round_robin();
    test_priority();
    test_hit();
    test_init_in_run();
    test_random();
`ifdef NBDCACHE_ARB_CONFLICT_CNT_EN
    test_conflict_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
